obc_da_engine: RTL and testbench

OBC_DA_ENGINE -- requirements
Module: obc_da_engine

---
 rtl/obc_da_engine_if.sv | 49 ++++
 rtl/obc_da_engine.sv | 164 ++++++++++++++++
 tb/tb_obc_da_engine.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/obc_da_engine_if.sv
// obc_da_engine_if -- bus bundle for the offset-binary-coded distributed
// arithmetic engine.
//
// Parameters must match the engine instance: N_IN samples of DW bits and
// CW-bit coefficient table entries.
//
// Signals:
//   in_valid/in_ready   sample vector handshake, x_in carries N_IN samples
//   cfg_we/addr/data    coefficient table write port (pair k, entry e -> 2k+e)
//   off_we/off_data     offset register write port (AW bits)
//   out_valid/out_ready result handshake, result is OW bits
//
// Modports: master drives the inputs of the engine, slave is the engine.
// Macro OBC_DA_ROUND_EN narrows result to AW-DW bits (rounded output).
interface obc_da_engine_if #(
  parameter int N_IN = 16,
  parameter int DW   = 8,
  parameter int CW   = 16
);
  localparam int AW  = CW + DW + $clog2(N_IN / 2) + 1;
  localparam int CAW = $clog2(N_IN);
`ifdef OBC_DA_ROUND_EN
  localparam int OW  = AW - DW;
`else
  localparam int OW  = AW;
`endif

  logic                 in_valid;
  logic                 in_ready;
  logic [N_IN*DW-1:0]   x_in;
  logic                 cfg_we;
  logic [CAW-1:0]       cfg_addr;
  logic [CW-1:0]        cfg_data;
  logic                 off_we;
  logic [AW-1:0]        off_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [OW-1:0]        result;

  modport master (
    output in_valid, x_in, cfg_we, cfg_addr, cfg_data, off_we, off_data, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, x_in, cfg_we, cfg_addr, cfg_data, off_we, off_data, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/obc_da_engine.sv
// obc_da_engine -- bit-serial distributed arithmetic inner product using
// offset binary coding. Samples are paired; each pair (2k, 2k+1) owns a
// two-entry coefficient table T[k][0..1]. One bit plane is processed per
// clock, MSB plane first, so a vector takes DW cycles in RUN plus one cycle
// to add the offset register and present the result.
//
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset (clears FSM, table and offset)
//   bus    obc_da_engine_if.slave: vector input, table/offset writes,
//          result output with valid/ready
//
// Optional feature: define OBC_DA_ROUND_EN to output the final sum divided
// by 2^DW with round-half-up, AW-DW bits wide. Without it the full AW-bit
// sum is output.
module obc_da_engine #(
  parameter int N_IN = 16,
  parameter int DW   = 8,
  parameter int CW   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  obc_da_engine_if.slave  bus
);
  localparam int AW = CW + DW + $clog2(N_IN / 2) + 1;
  localparam int NP = N_IN / 2;
  localparam int JW = (DW > 1) ? $clog2(DW) : 1;
`ifdef OBC_DA_ROUND_EN
  localparam int OW = AW - DW;
  localparam logic [AW-1:0] RND = AW'(1) << (DW - 1);
`else
  localparam int OW = AW;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [JW-1:0]   j;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   off_reg;
  logic [DW-1:0]   smp [N_IN];
  logic [CW-1:0]   tbl [N_IN];
  logic            in_ready_q;
  logic            out_valid_q;
  logic [OW-1:0]   result_q;

  logic            inv;
  logic [AW-1:0]   term [NP];
  logic [AW-1:0]   plane_sum;
  logic [AW-1:0]   acc_next;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;

  // The MSB plane carries negative weight in two's complement; inverting its
  // sign here is what turns the offset-binary table lookup into a signed sum.
  assign inv = (j == JW'(DW - 1));

  for (genvar k = 0; k < NP; k++) begin : g_pair
    logic          b0, b1, idx, sgn;
    logic [CW-1:0] tsel;
    logic [AW-1:0] tv;

    assign b0   = smp[2*k][j];
    assign b1   = smp[2*k+1][j];
    assign idx  = b0 ^ b1;
    assign sgn  = b0 ^ inv;
    assign tsel = idx ? tbl[2*k+1] : tbl[2*k];
    assign tv   = {{(AW-CW){tsel[CW-1]}}, tsel};
    assign term[k] = sgn ? ((~tv) + AW'(1)) : tv;
  end

  // NOTE: every always_comb output gets a default before any conditional or
  // loop, so no path can leave it unassigned and infer a latch.
  always_comb begin
    plane_sum = '0;
    for (int k = 0; k < NP; k++) begin
      plane_sum = plane_sum + term[k];
    end
  end

  assign acc_next = (acc << 1) + plane_sum;

  // Table and offset are writable only while idle so that a vector in flight
  // always sees one consistent configuration. A write coinciding with the
  // accepting handshake lands on the same edge and is used by that vector.
  // NOTE: the coefficient table is a register file that must read back as
  // zero after reset, so it is cleared in the reset branch, unlike a RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IN; i++) begin
        tbl[i] <= '0;
      end
      off_reg <= '0;
    end else if (state == IDLE) begin
      if (bus.cfg_we && (int'(bus.cfg_addr) < N_IN)) begin
        tbl[bus.cfg_addr] <= bus.cfg_data;
      end
      if (bus.off_we) begin
        off_reg <= bus.off_data;
      end
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      j           <= JW'(DW - 1);
      acc         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      for (int i = 0; i < N_IN; i++) begin
        smp[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            for (int i = 0; i < N_IN; i++) begin
              smp[i] <= bus.x_in[i*DW +: DW];
            end
            acc        <= '0;
            j          <= JW'(DW - 1);
            in_ready_q <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          if (j == '0) begin
            state <= DONE;
          end else begin
            j <= j - JW'(1);
          end
        end
        DONE: begin
          // First DONE cycle adds the offset and raises out_valid; after that
          // result is frozen until the consumer takes it.
          if (!out_valid_q) begin
`ifdef OBC_DA_ROUND_EN
            result_q <= OW'($signed(acc + off_reg + RND) >>> DW);
`else
            result_q <= acc + off_reg;
`endif
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            j           <= JW'(DW - 1);
            state       <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_obc_da_engine.sv
// tb_obc_da_engine -- scoreboard bench for obc_da_engine (N_IN=16, DW=8,
// CW=16). Stimulus pushes hand-computed expected results and accept times;
// a monitor pops and compares on every result handshake, checks the
// accept-to-valid latency and checks that a stalled result stays put.
// Honours OBC_DA_ROUND_EN for the expected output format.
module tb_obc_da_engine;
  localparam int N_IN = 16;
  localparam int DW   = 8;
  localparam int CW   = 16;
  localparam int AW   = CW + DW + $clog2(N_IN / 2) + 1;
  localparam int XW   = N_IN * DW;
`ifdef OBC_DA_ROUND_EN
  localparam int OW   = AW - DW;
`else
  localparam int OW   = AW;
`endif

  logic clk;
  logic rst_n;

  obc_da_engine_if #(.N_IN(N_IN), .DW(DW), .CW(CW)) bus ();

  obc_da_engine #(.N_IN(N_IN), .DW(DW), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [OW-1:0] exp_q [$];
  time           acc_q [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout required event", name);
  endtask

  // Final sum -> output word as the engine presents it.
  function automatic logic [OW-1:0] to_out(input longint fin);
`ifdef OBC_DA_ROUND_EN
    longint r;
    r = (fin + (longint'(1) <<< (DW - 1))) >>> DW;
    return OW'(r);
`else
    return OW'(fin);
`endif
  endfunction

  function automatic logic [XW-1:0] one_sample(input int i, input logic [DW-1:0] v);
    logic [XW-1:0] r;
    r = '0;
    r[i*DW +: DW] = v;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) bound_fail("wait_idle");
  endtask

  task automatic wr_cfg(input int addr, input logic [CW-1:0] data);
    wait_idle();
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 4'(addr);
    bus.cfg_data = data;
    tick();
    bus.cfg_we   = 1'b0;
  endtask

  task automatic wr_off(input longint v);
    wait_idle();
    bus.off_we   = 1'b1;
    bus.off_data = v[AW-1:0];
    tick();
    bus.off_we   = 1'b0;
  endtask

  // Returns one cycle after the accepting edge (engine is then in RUN).
  task automatic send(input logic [XW-1:0] x, input longint fin, input bit push);
    wait_idle();
    bus.in_valid = 1'b1;
    bus.x_in     = x;
    if (push) exp_q.push_back(to_out(fin));
    tick();
    if (push) acc_q.push_back($time - 1);
    bus.in_valid = 1'b0;
  endtask

  // Monitor: latency on each rising out_valid, value on each handshake,
  // stability while the consumer stalls.
  logic          ov_last   = 1'b0;
  logic          hold_pend = 1'b0;
  logic [OW-1:0] held_res  = '0;

  always @(negedge clk) begin
    if (hold_pend) begin
      check("hold_valid", 64'(bus.out_valid), 64'(1));
      check("hold_result", 64'(bus.result), 64'(held_res));
    end
    if (bus.out_valid && !ov_last) begin
      if (acc_q.size() == 0) bound_fail("unexpected_valid");
      else check("latency", 64'(($time - acc_q.pop_front() - 5) / 10), 64'(DW + 1));
    end
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) bound_fail("unexpected_result");
      else check("result", 64'(bus.result), 64'(exp_q.pop_front()));
    end
    hold_pend = bus.out_valid && !bus.out_ready;
    held_res  = bus.result;
    ov_last   = bus.out_valid;
  end

  initial begin
    logic [XW-1:0] ones;
    logic [XW-1:0] zeros;
    int            n;
    bit            saw;

    ones  = '1;
    zeros = '0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.x_in      = '0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    bus.off_we    = 1'b0;
    bus.off_data  = '0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state.
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_result", 64'(bus.result), 64'(0));

    // Empty table: result is the offset whatever the samples.
    wr_off(5);
    send({32'h0123_4567, 32'h89ab_cdef, 32'hdead_beef, 32'h7f80_01ff}, 5, 1);
    send(ones, 5, 1);

    // Single coefficient T[0][0]=100.
    wr_off(0);
    wr_cfg(0, 16'd100);
    send(zeros, -100, 1);
    send(ones, 100, 1);

    // Consumer stall: result held, engine busy, then back to idle.
    wait_idle();
    bus.out_ready = 1'b0;
    send(ones, 100, 1);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) bound_fail("stall_wait_valid");
    for (int i = 0; i < 5; i++) begin
      check("stall_in_ready", 64'(bus.in_ready), 64'(0));
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    check("stall_release_in_ready", 64'(bus.in_ready), 64'(1));
    check("stall_release_out_valid", 64'(bus.out_valid), 64'(0));

    // Writes during RUN are ignored.
    send(zeros, -100, 1);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 4'd0;
    bus.cfg_data = 16'd7;
    bus.off_we   = 1'b1;
    bus.off_data = AW'(99);
    tick();
    bus.cfg_we   = 1'b0;
    bus.off_we   = 1'b0;
    send(ones, 100, 1);

    // Write coinciding with accept is used by that vector.
    wait_idle();
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 4'd0;
    bus.cfg_data = 16'd50;
    send(zeros, -50, 1);
    bus.cfg_we   = 1'b0;
    send(ones, 50, 1);

    // Pair 1 with both entries used: T[1][0]=10, T[1][1]=3.
    wr_cfg(0, 16'd0);
    wr_cfg(2, 16'd10);
    wr_cfg(3, 16'd3);
    send(one_sample(2, 8'h01), -23, 1);
    send(one_sample(3, 8'h01), -17, 1);
    send(one_sample(2, 8'h80), 1654, 1);

    // Highest table address, negative coefficient, negative offset.
    wr_cfg(2, 16'd0);
    wr_cfg(3, 16'd0);
    wr_cfg(15, 16'hfffe);
    send(one_sample(14, 8'h7f), 254, 1);
    wr_off(-1000);
    send(one_sample(14, 8'h7f), -746, 1);

    // Larger coefficient (rounded build gives +4 / -4).
    wr_off(0);
    wr_cfg(15, 16'd0);
    wr_cfg(0, 16'd1000);
    send(ones, 1000, 1);
    send(zeros, -1000, 1);

    // Reset in the middle of RUN abandons the vector and clears config.
    wr_off(5);
    send(ones, 0, 0);
    tick();
    tick();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    check("midrun_rst_in_ready", 64'(bus.in_ready), 64'(1));
    check("midrun_rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("midrun_rst_result", 64'(bus.result), 64'(0));
    saw = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.out_valid) saw = 1'b1;
    end
    check("midrun_no_valid", 64'(saw), 64'(0));
    send(ones, 0, 1);

    // Drain the scoreboard.
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
